// File: rtl/seg_display_scanner.sv
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment display.
// Snapshots value/dp once per frame, blanks between digits, optionally blanks leading zeros.
module seg_display_scanner #(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 1000,
  parameter int LZ_BLANK     = 1
) (
  input  logic        clock,
  input  logic        reset_in,
  input  logic        enable,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  output logic [3:0]  disp_anode,
  output logic [7:0]  disp_seg,
  output logic        frame_start
);

  localparam int CNT_W = $clog2(CLK_DIV);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      snap_val_q, snap_val_d;
  logic [3:0]       snap_dp_q, snap_dp_d;
  logic [3:0]       anode_q, anode_d;
  logic [7:0]       seg_q, seg_d;
  logic             frame_start_q, frame_start_d;

  logic [3:0]       cur_nib;
  logic             cur_dp;
  logic             glyph_blank;

  function automatic logic [6:0] encode(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  always_ff @(posedge clock or negedge reset_in) begin
    if (!reset_in) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      snap_val_q    <= '0;
      snap_dp_q     <= '0;
      anode_q       <= 4'hF;
      seg_q         <= 8'hFF;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      snap_val_q    <= snap_val_d;
      snap_dp_q     <= snap_dp_d;
      anode_q       <= anode_d;
      seg_q         <= seg_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Snapshot loads only when a frame begins (leaving IDLE or wrapping digit 3 -> 0).
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    snap_val_d    = snap_val_q;
    snap_dp_d     = snap_dp_q;
    frame_start_d = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d       = BLANK;
          cnt_d         = '0;
          idx_d         = '0;
          snap_val_d    = value;
          snap_dp_d     = dp_in;
          frame_start_d = 1'b1;
        end
        BLANK: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) state_d = SHOW;
        end
        SHOW: begin
          if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
            cnt_d   = '0;
            idx_d   = idx_q + 1'b1;
            state_d = BLANK;
            if (idx_q == 2'd3) begin
              snap_val_d    = value;
              snap_dp_d     = dp_in;
              frame_start_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // A leading-zero glyph is suppressed unless a lit DP sits to its left; its own DP still lights.
  always_comb begin
    cur_nib     = snap_val_q[4*idx_q +: 4];
    cur_dp      = snap_dp_q[idx_q];
    glyph_blank = (LZ_BLANK != 0) && (idx_q != 2'd0);
    for (int j = 1; j < 4; j++) begin
      if (idx_q <= 2'(j) && snap_val_q[4*j +: 4] != 4'h0) glyph_blank = 1'b0;
      if (idx_q < 2'(j) && snap_dp_q[j]) glyph_blank = 1'b0;
    end
  end

  always_comb begin
    anode_d = 4'hF;
    seg_d   = 8'hFF;
    if (enable && state_q == SHOW) begin
      anode_d = ~(4'b0001 << idx_q);
      seg_d   = {~cur_dp, glyph_blank ? 7'h7F : encode(cur_nib)};
    end
  end

  assign disp_anode  = anode_q;
  assign disp_seg    = seg_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Directed-vector bench for seg_display_scanner with CLK_DIV=8, BLANK_CYCLES=2, LZ_BLANK=1.
module tb_seg_display_scanner;

  logic        clock;
  logic        reset_in;
  logic        enable;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  disp_anode;
  logic [7:0]  disp_seg;
  logic        frame_start;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0]     val;
    logic [3:0]      dp;
    logic [3:0][7:0] segs;
  } vec_t;

  vec_t vecs[12];

  seg_display_scanner #(
    .CLK_DIV      (8),
    .BLANK_CYCLES (2),
    .LZ_BLANK     (1)
  ) dut (
    .clock       (clock),
    .reset_in    (reset_in),
    .enable      (enable),
    .value       (value),
    .dp_in       (dp_in),
    .disp_anode  (disp_anode),
    .disp_seg    (disp_seg),
    .frame_start (frame_start)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    n_cmp++;
    if ($countones(~disp_anode) > 1) begin
      n_fail++;
      $display("[TB] FAIL onehot_anode: got %h required at most one low", disp_anode);
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic wait_frame_start(output int cycles);
    cycles = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      cycles++;
      if (frame_start) return;
    end
    n_cmp++;
    n_fail++;
    $display("[TB] FAIL frame_start_timeout: got none required pulse within 200 cycles");
  endtask

  // Starts on the sample where frame_start is high; ends on the next frame_start sample.
  task automatic check_frame(input vec_t v, input logic [15:0] nv, input logic [3:0] ndp);
    int d, c, dig;
    logic [3:0] ea;
    logic [7:0] es;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clock);
      d = k / 8;
      c = k % 8;
      if (c == 1 || c == 2) begin
        ea = 4'hF;
        es = 8'hFF;
      end else begin
        dig = (c == 0) ? d - 1 : d;
        ea  = ~(4'b0001 << dig);
        es  = v.segs[dig];
      end
      check($sformatf("anode val=%h k=%0d", v.val, k), {4'h0, disp_anode}, {4'h0, ea});
      check($sformatf("seg val=%h k=%0d", v.val, k), disp_seg, es);
      check($sformatf("frame_start val=%h k=%0d", v.val, k), {7'h0, frame_start},
            {7'h0, (k == 32)});
      if (k == 20) begin
        value = nv;
        dp_in = ndp;
      end
    end
  endtask

  initial begin
    int cyc;
    vecs[0]  = '{16'h1234, 4'b0000, {8'hF9, 8'hA4, 8'hB0, 8'h99}};
    vecs[1]  = '{16'h0005, 4'b0000, {8'hFF, 8'hFF, 8'hFF, 8'h92}};
    vecs[2]  = '{16'h0005, 4'b0100, {8'hFF, 8'h7F, 8'hC0, 8'h92}};
    vecs[3]  = '{16'hAAAA, 4'b0000, {8'h88, 8'h88, 8'h88, 8'h88}};
    vecs[4]  = '{16'hFFFF, 4'b1111, {8'h0E, 8'h0E, 8'h0E, 8'h0E}};
    vecs[5]  = '{16'h0000, 4'b0000, {8'hFF, 8'hFF, 8'hFF, 8'hC0}};
    vecs[6]  = '{16'h0080, 4'b0000, {8'hFF, 8'hFF, 8'h80, 8'hC0}};
    vecs[7]  = '{16'h8000, 4'b0001, {8'h80, 8'hC0, 8'hC0, 8'h40}};
    vecs[8]  = '{16'h0B0D, 4'b0000, {8'hFF, 8'h83, 8'hC0, 8'hA1}};
    vecs[9]  = '{16'h0000, 4'b1000, {8'h7F, 8'hC0, 8'hC0, 8'hC0}};
    vecs[10] = '{16'h6789, 4'b0000, {8'h82, 8'hF8, 8'h80, 8'h90}};
    vecs[11] = '{16'hCE00, 4'b0000, {8'hC6, 8'h86, 8'hC0, 8'hC0}};

    reset_in = 1'b0;
    enable   = 1'b1;
    value    = vecs[0].val;
    dp_in    = vecs[0].dp;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("reset_anode", {4'h0, disp_anode}, 8'h0F);
      check("reset_seg", disp_seg, 8'hFF);
      check("reset_frame_start", {7'h0, frame_start}, 8'h00);
    end
    reset_in = 1'b1;
    wait_frame_start(cyc);
    check("first_frame_latency", 8'(cyc), 8'd1);

    for (int i = 0; i < 12; i++)
      check_frame(vecs[i], vecs[(i + 1) % 12].val, vecs[(i + 1) % 12].dp);

    // Drop enable while digit 1 is showing, then re-enable.
    for (int k = 1; k <= 12; k++) @(negedge clock);
    check("pre_drop_anode", {4'h0, disp_anode}, 8'h0D);
    check("pre_drop_seg", disp_seg, 8'hB0);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("idle_anode", {4'h0, disp_anode}, 8'h0F);
      check("idle_seg", disp_seg, 8'hFF);
      check("idle_frame_start", {7'h0, frame_start}, 8'h00);
    end
    enable = 1'b1;
    @(negedge clock);
    check("reenable_frame_start", {7'h0, frame_start}, 8'h01);
    check_frame(vecs[0], vecs[0].val, vecs[0].dp);

    // Random values; frame period must stay at 4*CLK_DIV.
    for (int f = 0; f < 200; f++) begin
      value = 16'($urandom);
      dp_in = 4'($urandom);
      wait_frame_start(cyc);
      check("frame_period", 8'(cyc), 8'd32);
    end

    // Asynchronous reset mid-slot darkens the pins without waiting for a clock edge.
    cyc = 0;
    while (disp_anode == 4'hF && cyc < 40) begin
      @(negedge clock);
      cyc++;
    end
    check("lit_before_async_reset", {7'h0, (disp_anode != 4'hF)}, 8'h01);
    #2 reset_in = 1'b0;
    #1;
    check("async_reset_anode", {4'h0, disp_anode}, 8'h0F);
    check("async_reset_seg", disp_seg, 8'hFF);
    @(negedge clock);
    reset_in = 1'b1;
    @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
